// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave register file with independent write and read FSMs.
// Define AXI4_LITE_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axi4_lite_slave_regs #(
    parameter int NUM_REGS = 16
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [7:0]  AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    input  logic [7:0]  ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY
);

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI4_LITE_SLVERR_EN
    localparam logic [1:0] RESP_OOR = 2'b10;
`else
    localparam logic [1:0] RESP_OOR = 2'b00;
`endif

    typedef enum logic { W_IDLE, W_RESP } w_state_e;
    typedef enum logic { R_IDLE, R_DATA } r_state_e;

    w_state_e    w_state_q, w_state_d;
    r_state_e    r_state_q, r_state_d;
    logic        rdy_q, rdy_d;
    logic        aw_got_q, aw_got_d;
    logic        w_got_q, w_got_d;
    logic [5:0]  awidx_q, awidx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];

    logic        aw_fire, w_fire, ar_fire;
    logic [5:0]  wr_idx, rd_idx;
    logic [31:0] wr_data, rd_word;
    logic [3:0]  wr_strb;
    logic        wr_in_range, rd_in_range;
    logic        addr_lsb_unused;

    assign addr_lsb_unused = ^{AWADDR[1:0], ARADDR[1:0]};

    // Readies come only from flops; rdy_q holds them low for the first cycle out of reset.
    assign AWREADY = rdy_q && (w_state_q == W_IDLE) && !aw_got_q;
    assign WREADY  = rdy_q && (w_state_q == W_IDLE) && !w_got_q;
    assign ARREADY = rdy_q && (r_state_q == R_IDLE);
    assign BVALID  = (w_state_q == W_RESP);
    assign RVALID  = (r_state_q == R_DATA);
    assign BRESP   = bresp_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    assign aw_fire = AWVALID && AWREADY;
    assign w_fire  = WVALID && WREADY;
    assign ar_fire = ARVALID && ARREADY;

    assign wr_idx  = aw_got_q ? awidx_q : AWADDR[7:2];
    assign wr_data = w_got_q ? wdata_q : WDATA;
    assign wr_strb = w_got_q ? wstrb_q : WSTRB;
    assign rd_idx  = ARADDR[7:2];

    assign wr_in_range = {1'b0, wr_idx} < 7'(NUM_REGS);
    assign rd_in_range = {1'b0, rd_idx} < 7'(NUM_REGS);

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == 6'(i)) rd_word = regs_q[i];
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        rdy_d     = 1'b1;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        awidx_d   = awidx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_fire) begin
                    aw_got_d = 1'b1;
                    awidx_d  = AWADDR[7:2];
                end
                if (w_fire) begin
                    w_got_d = 1'b1;
                    wdata_d = WDATA;
                    wstrb_d = WSTRB;
                end
                if ((aw_got_q || aw_fire) && (w_got_q || w_fire)) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wr_in_range && wr_idx == 6'(i) && wr_strb[b])
                                regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
                        end
                    end
                    bresp_d   = wr_in_range ? RESP_OKAY : RESP_OOR;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) w_state_d = W_IDLE;
            end
        endcase
    end

    // Reads sample regs_q, so a same-edge write is not visible yet.
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_fire) begin
                    rdata_d   = rd_in_range ? rd_word : '0;
                    rresp_d   = rd_in_range ? RESP_OKAY : RESP_OOR;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY) r_state_d = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            rdy_q     <= 1'b0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            regs_q    <= '{default: '0};
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            rdy_q     <= rdy_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awidx_q   <= awidx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            regs_q    <= regs_d;
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed bench for axi4_lite_slave_regs (NUM_REGS = 16).
// Expected out-of-range response follows AXI4_LITE_SLVERR_EN.
module tb_axi4_lite_slave_regs;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [7:0]  AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [7:0]  ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b0;

`ifdef AXI4_LITE_SLVERR_EN
    localparam logic [1:0] EXP_OOR = 2'b10;
`else
    localparam logic [1:0] EXP_OOR = 2'b00;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_regs [16];
    logic [1:0]  resp;
    logic [31:0] rd;

    axi4_lite_slave_regs #(.NUM_REGS(16)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] r);
        bit aw_done = 0;
        bit w_done = 0;
        int n = 0;
        AWADDR = a; WDATA = d; WSTRB = s;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            if (AWVALID && AWREADY) aw_done = 1;
            if (WVALID && WREADY) w_done = 1;
            tick();
            n++;
            if (aw_done) AWVALID = 1'b0;
            if (w_done) WVALID = 1'b0;
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("wr_accept", {30'd0, aw_done, w_done}, 32'd3);
        n = 0;
        while (!BVALID && n < 20) begin tick(); n++; end
        chk("wr_bvalid", {31'd0, BVALID}, 32'd1);
        r = BRESP;
        tick();
        chk("wr_bclear", {31'd0, BVALID}, 32'd0);
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d,
                            output logic [1:0] r);
        int n = 0;
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
        while (!ARREADY && n < 20) begin tick(); n++; end
        chk("rd_arready", {31'd0, ARREADY}, 32'd1);
        tick();
        ARVALID = 1'b0;
        chk("rd_rvalid", {31'd0, RVALID}, 32'd1);
        d = RDATA;
        r = RRESP;
        tick();
        chk("rd_rclear", {31'd0, RVALID}, 32'd0);
        RREADY = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) exp_regs[i] = '0;

        // Reset values
        tick(); tick();
        chk("rst_awready", {31'd0, AWREADY}, 32'd0);
        chk("rst_wready", {31'd0, WREADY}, 32'd0);
        chk("rst_arready", {31'd0, ARREADY}, 32'd0);
        chk("rst_bvalid", {31'd0, BVALID}, 32'd0);
        chk("rst_rvalid", {31'd0, RVALID}, 32'd0);
        chk("rst_bresp", {30'd0, BRESP}, 32'd0);
        chk("rst_rresp", {30'd0, RRESP}, 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
        ARESETN = 1'b1;
        #1;
        chk("rel_arready_pre", {31'd0, ARREADY}, 32'd0);
        tick();
        chk("rel_awready", {31'd0, AWREADY}, 32'd1);
        chk("rel_wready", {31'd0, WREADY}, 32'd1);
        chk("rel_arready", {31'd0, ARREADY}, 32'd1);

        // Full-word write then read back
        axi_write(8'h08, 32'hDEADBEEF, 4'hF, resp);
        exp_regs[2] = 32'hDEADBEEF;
        chk("w08_bresp", {30'd0, resp}, 32'd0);
        axi_read(8'h08, rd, resp);
        chk("r08_data", rd, 32'hDEADBEEF);
        chk("r08_rresp", {30'd0, resp}, 32'd0);

        // Byte strobes
        axi_write(8'h04, 32'h11223344, 4'hF, resp);
        axi_write(8'h04, 32'hAABBCCDD, 4'b0101, resp);
        exp_regs[1] = 32'h11BB33DD;
        axi_read(8'h04, rd, resp);
        chk("r04_strb", rd, 32'h11BB33DD);

        // Zero strobe changes nothing
        axi_write(8'h04, 32'hFFFFFFFF, 4'b0000, resp);
        axi_read(8'h04, rd, resp);
        chk("r04_nostrb", rd, 32'h11BB33DD);

        // W three cycles ahead of AW, BREADY held low
        AWADDR = 8'h0C; WDATA = 32'h5; WSTRB = 4'hF;
        WVALID = 1'b1; BREADY = 1'b0;
        chk("wf_wready", {31'd0, WREADY}, 32'd1);
        tick();
        WVALID = 1'b0;
        chk("wf_wready_drop", {31'd0, WREADY}, 32'd0);
        chk("wf_awready", {31'd0, AWREADY}, 32'd1);
        tick(); tick();
        chk("wf_no_b", {31'd0, BVALID}, 32'd0);
        AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        exp_regs[3] = 32'h5;
        for (int i = 0; i < 4; i++) begin
            chk("wf_bhold", {31'd0, BVALID}, 32'd1);
            chk("wf_awready_b", {31'd0, AWREADY}, 32'd0);
            chk("wf_wready_b", {31'd0, WREADY}, 32'd0);
            if (i < 3) tick();
        end
        chk("wf_bresp", {30'd0, BRESP}, 32'd0);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        chk("wf_bclear", {31'd0, BVALID}, 32'd0);
        axi_read(8'h0C, rd, resp);
        chk("r0c_data", rd, 32'h5);

        // Out-of-range access
        axi_write(8'h40, 32'hFFFFFFFF, 4'hF, resp);
        chk("oor_bresp", {30'd0, resp}, {30'd0, EXP_OOR});
        axi_read(8'h40, rd, resp);
        chk("oor_rdata", rd, 32'd0);
        chk("oor_rresp", {30'd0, resp}, {30'd0, EXP_OOR});
        for (int i = 0; i < 16; i++) begin
            axi_read(8'(4 * i), rd, resp);
            chk("oor_regs", rd, exp_regs[i]);
        end

        // Same-edge write and read of one register
        AWADDR = 8'h10; WDATA = 32'h77; WSTRB = 4'hF; ARADDR = 8'h10;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
        BREADY = 1'b1; RREADY = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        chk("same_rvalid", {31'd0, RVALID}, 32'd1);
        chk("same_bvalid", {31'd0, BVALID}, 32'd1);
        chk("same_rdata_old", RDATA, 32'd0);
        tick();
        BREADY = 1'b0; RREADY = 1'b0;
        axi_read(8'h10, rd, resp);
        chk("same_rdata_new", rd, 32'h77);

        // Asynchronous reset while read data is pending
        axi_write(8'h14, 32'h12345678, 4'hF, resp);
        ARADDR = 8'h14; ARVALID = 1'b1; RREADY = 1'b0;
        chk("ar_ready", {31'd0, ARREADY}, 32'd1);
        tick();
        ARVALID = 1'b0;
        chk("ar_rvalid", {31'd0, RVALID}, 32'd1);
        chk("ar_rdata", RDATA, 32'h12345678);
        tick();
        chk("ar_rhold", {31'd0, RVALID}, 32'd1);
        chk("ar_arready_hold", {31'd0, ARREADY}, 32'd0);
        #2;
        ARESETN = 1'b0;
        #1;
        chk("arst_rvalid", {31'd0, RVALID}, 32'd0);
        chk("arst_awready", {31'd0, AWREADY}, 32'd0);
        chk("arst_wready", {31'd0, WREADY}, 32'd0);
        chk("arst_arready", {31'd0, ARREADY}, 32'd0);
        chk("arst_rdata", RDATA, 32'd0);
        tick(); tick();
        ARESETN = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            axi_read(8'(4 * i), rd, resp);
            chk("arst_regs", rd, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_regs.md
# axi4_lite_slave_regs

AXI4-Lite slave register file: the downstream consumer of the team's AXI4-Lite interface, bound through its `dut` modport. Accepts single-beat writes and reads on an 8-bit byte address space and returns responses on B and R. Holds NUM_REGS 32-bit control/status registers with byte-strobe writes. Write and read paths are independent FSMs and may be active concurrently.

## Interface
- NUM_REGS, 16, number of 32-bit registers; legal range 1..64; register i sits at byte address 4*i
- ACLK  input  1  clock; all state updates on rising edge
- ARESETN  input  1  asynchronous active-low reset
- AWADDR  input  8  write byte address; bits [1:0] ignored
- AWVALID / AWREADY  input / output  1 / 1  write-address handshake
- WDATA  input  32  write data
- WSTRB  input  4  byte enables; bit k enables WDATA[8k+7:8k]
- WVALID / WREADY  input / output  1 / 1  write-data handshake
- BRESP  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR
- BVALID / BREADY  output / input  1 / 1  write-response handshake
- ARADDR  input  8  read byte address; bits [1:0] ignored
- ARVALID / ARREADY  input / output  1 / 1  read-address handshake
- RDATA  output  32  read data
- RRESP  output  2  read response, same encoding as BRESP
- RVALID / RREADY  output / input  1 / 1  read-data handshake

## Operation
- Index = ADDR[7:2]; in range iff index < NUM_REGS.
- Write FSM states: W_IDLE, W_RESP. Flags aw_got, w_got latch AWADDR and WDATA/WSTRB on their handshakes.
  - W_IDLE: AWREADY = !aw_got; WREADY = !w_got. AW and W are accepted in either order or in the same cycle.
  - On the edge where the second of AW/W completes, the register update commits. The update uses captured or current-cycle values, only strobed bytes change, and a WSTRB of 4'b0000 changes nothing.
  - On that same edge, BRESP is set, the flags clear, and the FSM goes to W_RESP.
  - W_RESP: BVALID=1, AWREADY=WREADY=0. On the BVALID&&BREADY edge, go to W_IDLE.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On the AR handshake edge, RDATA and RRESP are registered and the FSM goes to R_DATA.
  - R_DATA: RVALID=1, ARREADY=0. RDATA and RRESP stay stable until the RVALID&&RREADY edge, then the FSM goes to R_IDLE.
- Out-of-range write: no register changes. Out-of-range read: RDATA=0. Response value per Configuration.
- Read and write to the same register on the same edge: the read returns the pre-write value.

## Timing
- Reset values (ARESETN low, asynchronous): all registers 0; AWREADY=WREADY=ARREADY=0; BVALID=RVALID=0; BRESP=RRESP=2'b00; RDATA=0. Both FSMs return to idle and aw_got/w_got clear.
- Readies assert 1 cycle after ARESETN deasserts, as the first edge leaves the reset state. Readies are decoded from flops only, with no combinational path from any input.
- Write latency: with AW and W in the same cycle at edge N, BVALID=1 from edge N to the BREADY edge. The next AW/W is accepted no earlier than the cycle after the B handshake.
- Read latency: AR handshake at edge N gives RVALID=1 after edge N. Back-to-back reads achieve 1 read per 2 cycles.
- BREADY/RREADY low: the response is held indefinitely, and no further AW/W (or AR) is accepted.
- AW arriving with no W: AWREADY drops after capture, and the FSM waits in W_IDLE for W indefinitely. The symmetric case holds for W with no AW.
- ARESETN asserted mid-transaction: pending AW/W/AR and unretired B/R are dropped with no response. Registers are cleared.

## Configuration
- AXI4_LITE_SLVERR_EN defined: an out-of-range address returns BRESP/RRESP = 2'b10 (SLVERR).
- Not defined: an out-of-range address returns 2'b00 (OKAY), with writes silently discarded and reads returning 0.
- In-range behaviour is identical in both builds.

## Test plan
- Reset, then AW=0x08 and W=0xDEADBEEF with WSTRB=4'hF in the same cycle, BREADY=1 -> BVALID for 1 cycle with BRESP=00. Then AR=0x08 -> RVALID next cycle, RDATA=0xDEADBEEF, RRESP=00.
- Write 0x11223344 to 0x04, then write 0xAABBCCDD with WSTRB=4'b0101 -> read 0x04 returns 0x11BB33DD.
- W presented 3 cycles before AW (addr 0x0C, data 0x5), with BREADY low for 4 cycles after BVALID -> WREADY drops after W capture, BVALID holds 4 cycles, and a read of 0x0C returns 0x5. AWREADY=0 while BVALID=1.
- NUM_REGS=16, write 0x40 data 0xFFFFFFFF, then read 0x40 -> RDATA=0. BRESP/RRESP=2'b10 with AXI4_LITE_SLVERR_EN, 2'b00 without. All 16 registers remain unchanged.
- Same-edge write 0x77 to 0x10 and AR 0x10 (old value 0) -> RDATA=0. A subsequent read returns 0x77.
- Assert ARESETN low while RVALID=1 holding 0x12345678 -> RVALID=0 and all readies 0 immediately, with no clock edge required. After release, all registers read 0.
